// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  // M-extension instructions carry this Funct7; Funct3 then selects the op.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  // All divide/remainder encodings have Funct3[2] set.
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: Start/Busy/Done request bus between the execute-stage controller
// (master) and the multiply/divide unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  modport master (
    output Start, Flush, Funct3, SrcA, SrcB,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Flush, Funct3, SrcA, SrcB,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: WIDTH-step iterative datapath on unsigned magnitudes.
// Multiply: shift-add, {hi,lo} ends as the 2*WIDTH product (multiplier starts in lo).
// Divide: restoring shift-subtract, lo ends as quotient and hi as remainder.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_last
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_diff;

  // Partial-product add keeps its carry; trial subtraction borrow decides the quotient bit.
  assign w_sum  = {1'b0, r_hi} + {1'b0, i_b};
  assign w_shl  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, i_b};

  assign o_lo   = r_lo;
  assign o_hi   = r_hi;
  assign o_last = (r_count == CW'(WIDTH - 1));

  // One multiply or divide step per enabled cycle; load restarts the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_lo    <= i_a;
      r_hi    <= '0;
      r_count <= '0;
    end else if (i_step) begin
      r_count <= r_count + CW'(1);
      if (i_is_div) begin
        r_hi <= w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else if (r_lo[0]) begin
        {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
      end else begin
        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (FSM, sign handling,
// divide-by-zero / signed-overflow short path, Result register).
// Optional macro MULDIV_FAST_MUL_EN: multiplies skip CALC and form the product
// combinationally in FIX (latency 2); divides always iterate.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  muldiv_state_e    r_state;
  muldiv_op_e       r_op;
  logic             r_busy;
  logic             r_done;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_short;
  logic [WIDTH-1:0] r_b_mag;
  logic [WIDTH-1:0] r_short_res;
  logic [WIDTH-1:0] r_result;

  muldiv_op_e         w_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div0;
  logic               w_ovf;
  logic               w_fast;
  logic               w_launch;
  logic [WIDTH-1:0]   w_short_res;
  logic [WIDTH-1:0]   w_core_lo;
  logic [WIDTH-1:0]   w_core_hi;
  logic               w_core_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_res;

  // Operand signedness: MULH both, MULHSU only rs1, DIV/REM both.
  assign w_op    = muldiv_op_e'(bus.Funct3);
  assign w_a_neg = bus.SrcA[WIDTH-1] &
                   (w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM);
  assign w_b_neg = bus.SrcB[WIDTH-1] &
                   (w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM);
  // Negating MIN_NEG gives MIN_NEG, which is the correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? -bus.SrcA : bus.SrcA;
  assign w_b_mag = w_b_neg ? -bus.SrcB : bus.SrcB;

  assign w_div0   = op_is_div(w_op) && (bus.SrcB == '0);
  assign w_ovf    = (w_op == OP_DIV || w_op == OP_REM) &&
                    (bus.SrcA == MIN_NEG) && (bus.SrcB == ALL_ONES);
  assign w_launch = (r_state == S_IDLE) && bus.Start && !bus.Flush;

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast = !op_is_div(w_op);
`else
  assign w_fast = 1'b0;
`endif

  // Short-path answers are fixed by the raw operands, so resolve them at launch.
  always_comb begin
    w_short_res = '0;
    if (w_div0) begin
      w_short_res = w_op[1] ? bus.SrcA : ALL_ONES;
    end else if (w_ovf) begin
      w_short_res = w_op[1] ? '0 : MIN_NEG;
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_launch),
    .i_step   (r_state == S_CALC),
    .i_is_div (op_is_div(r_op)),
    .i_a      (w_a_mag),
    .i_b      (r_b_mag),
    .o_lo     (w_core_lo),
    .o_hi     (w_core_hi),
    .o_last   (w_core_last)
  );

`ifdef MULDIV_FAST_MUL_EN
  // The core's lo register still holds |SrcA| because it never stepped.
  assign w_prod = {{WIDTH{1'b0}}, w_core_lo} * {{WIDTH{1'b0}}, r_b_mag};
`else
  assign w_prod = {w_core_hi, w_core_lo};
`endif

  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -w_core_lo : w_core_lo;
  assign w_rem      = r_neg_r ? -w_core_hi : w_core_hi;

  // Sign-corrected result selection applied in FIX.
  always_comb begin
    w_fix_res = '0;
    if (r_short) begin
      w_fix_res = r_short_res;
    end else begin
      case (r_op)
        OP_MUL:                       w_fix_res = w_prod_fix[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
        OP_DIV, OP_DIVU:              w_fix_res = w_quo;
        default:                      w_fix_res = w_rem;
      endcase
    end
  end

  // Control FSM with registered Busy/Done/Result; Flush wins over everything but reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_short     <= 1'b0;
      r_b_mag     <= '0;
      r_short_res <= '0;
      r_result    <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.Flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.Start) begin
              r_op        <= w_op;
              r_b_mag     <= w_b_mag;
              r_neg_q     <= w_a_neg ^ w_b_neg;
              r_neg_r     <= w_a_neg;
              r_short     <= w_div0 | w_ovf;
              r_short_res <= w_short_res;
              r_busy      <= 1'b1;
              r_state     <= (w_div0 || w_ovf || w_fast) ? S_FIX : S_CALC;
            end
          end
          S_CALC: begin
            if (w_core_last) r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= w_fix_res;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.Result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written flush/restart/reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
  localparam int PULSE_CYC = 1;
`else
  localparam int MUL_LAT = W + 2;
  localparam int PULSE_CYC = 5;
`endif
  localparam int DIV_LAT = W + 2;
  localparam int NV = 21;

  typedef struct {
    muldiv_op_e  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input muldiv_op_e f, input logic [31:0] a, input logic [31:0] b);
    bus.Start  = 1'b1;
    bus.Funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
  endtask

  // Launches one op (cycle 0) and waits a bounded number of cycles for Done.
  task automatic run_op(input muldiv_op_e f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    tick();
    drive_start(f, a, b);
    res = '0;
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= W + 10; c++) begin
      tick();
      bus.Start = 1'b0;
      if (bus.Done) begin
        lat = c;
        res = bus.Result;
        if (bus.Busy) busy_ok = 1'b0;
        break;
      end else if (!bus.Busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  vec_t vecs [NV];

  initial begin
    logic [31:0] res;
    int lat;
    bit busy_ok;
    int n_done;

    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{OP_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, MUL_LAT};
    vecs[5]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    vecs[6]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT};
    vecs[7]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT};
    vecs[8]  = '{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
    vecs[9]  = '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT};
    vecs[10] = '{OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, DIV_LAT};
    vecs[11] = '{OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DIV_LAT};
    vecs[12] = '{OP_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, DIV_LAT};
    vecs[13] = '{OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 2};
    vecs[14] = '{OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 2};
    vecs[15] = '{OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 2};
    vecs[16] = '{OP_REM,    32'h00000005, 32'h00000000, 32'h00000005, 2};
    vecs[17] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[18] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[19] = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT};
    vecs[20] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT};

    bus.Start  = 1'b0;
    bus.Flush  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    reset      = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_busy",   {31'b0, bus.Busy}, 32'd0);
    check("reset_done",   {31'b0, bus.Done}, 32'd0);
    check("reset_result", bus.Result,        32'd0);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busy_ok);
      $display("vec %0d op %0d a=%08h b=%08h -> result %08h done_cycle %0d", i,
               vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), {31'b0, busy_ok}, 32'd1);
    end

    // Flush in cycle 10 of DIVU 100/7, then restart in cycle 12
    tick();
    drive_start(OP_DIVU, 32'd100, 32'd7);
    n_done = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.Start = 1'b0;
      if (bus.Done) n_done++;
      if (c == 10) bus.Flush = 1'b1;
    end
    tick();
    bus.Flush = 1'b0;
    if (bus.Done) n_done++;
    check("flush_busy",    {31'b0, bus.Busy}, 32'd0);
    check("flush_no_done", 32'(n_done),       32'd0);
    check("flush_result",  bus.Result,        vecs[NV-1].res);
    $display("flush seq: busy %0b done_count %0d result %08h", bus.Busy, n_done, bus.Result);
    run_op(OP_DIVU, 32'd100, 32'd7, res, lat, busy_ok);
    $display("restart after flush: result %08h done_cycle %0d", res, lat);
    check("restart_result",  res,      32'd14);
    check("restart_latency", 32'(lat), 32'(DIV_LAT));

    // Start pulsed again while MUL 3*4 is busy
    tick();
    drive_start(OP_MUL, 32'd3, 32'd4);
    n_done = 0;
    lat = -1;
    res = '0;
    for (int c = 1; c <= W + 10; c++) begin
      tick();
      bus.Start = 1'b0;
      if (bus.Done) begin
        n_done++;
        if (lat < 0) begin
          lat = c;
          res = bus.Result;
        end
      end
      if (c == PULSE_CYC) drive_start(OP_MUL, 32'd5, 32'd5);
    end
    $display("busy restart seq: done_count %0d result %08h done_cycle %0d", n_done, res, lat);
    check("busy_start_ndone",   32'(n_done), 32'd1);
    check("busy_start_result",  res,         32'd12);
    check("busy_start_latency", 32'(lat),    32'(MUL_LAT));

    // Start in the DONE cycle of a short-path op is ignored
    tick();
    drive_start(OP_DIVU, 32'd5, 32'd0);
    n_done = 0;
    lat = -1;
    for (int c = 1; c <= W + 10; c++) begin
      tick();
      bus.Start = 1'b0;
      if (bus.Done) begin
        n_done++;
        if (lat < 0) lat = c;
      end
      if (c == 2) drive_start(OP_DIVU, 32'd9, 32'd3);
    end
    $display("done-cycle start seq: done_count %0d result %08h done_cycle %0d", n_done, bus.Result, lat);
    check("donecyc_ndone",   32'(n_done), 32'd1);
    check("donecyc_latency", 32'(lat),    32'd2);
    check("donecyc_result",  bus.Result,  32'hFFFFFFFF);

    // Reset in cycle 20 of a DIV
    tick();
    drive_start(OP_DIV, 32'd100, 32'd7);
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.Start = 1'b0;
      if (c == 20) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    check("midreset_busy",   {31'b0, bus.Busy}, 32'd0);
    check("midreset_done",   {31'b0, bus.Done}, 32'd0);
    check("midreset_result", bus.Result,        32'd0);
    n_done = 0;
    for (int c = 0; c < W + 10; c++) begin
      tick();
      if (bus.Done) n_done++;
    end
    $display("mid-op reset seq: done_count after reset %0d", n_done);
    check("midreset_no_done", 32'(n_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
